// File: rtl/issue_pair_splitter_if.sv
// Decode-to-issue bundle for the dual-issue pair splitter.
//
// Handshake: a pair transfers on a rising clk edge where in_valid & in_ready
// are both high; in_ready never depends on in_valid. The issue lanes use no
// ready of their own: a lane is issuing when its outN_valid is high and
// ex_stall is low, and while ex_stall is high the lanes hold their values.
interface issue_pair_splitter_if #(
    parameter int STAGE_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
);
    logic                   in_valid;
    logic [1:0]             in_slot_vld;
    logic [STAGE_WIDTH-1:0] in0;
    logic [STAGE_WIDTH-1:0] in1;
    logic [1:0]             in_solo;
    logic                   in_dep;
    logic                   in_ready;
    logic                   ex_stall;
    logic                   flush;
    logic [STAGE_WIDTH-1:0] out0;
    logic [STAGE_WIDTH-1:0] out1;
    logic                   out0_valid;
    logic                   out1_valid;
    logic                   split_active;
    logic [CNT_WIDTH-1:0]   split_cnt;

    // Environment side: decode plus the ID/EX stage.
    modport master (
        output in_valid, in_slot_vld, in0, in1, in_solo, in_dep, ex_stall, flush,
        input  in_ready, out0, out1, out0_valid, out1_valid, split_active, split_cnt
    );

    // Splitter side.
    modport slave (
        input  in_valid, in_slot_vld, in0, in1, in_solo, in_dep, ex_stall, flush,
        output in_ready, out0, out1, out0_valid, out1_valid, split_active, split_cnt
    );
endinterface

// File: rtl/issue_pair_splitter.sv
// Dual-issue dispatch buffer: holds one decoded pair and issues it to the two
// ID/EX lanes either together or, when the pair is illegal to co-issue,
// serialized as lane 0 then lane 1. Counts serialized pairs (saturating).
module issue_pair_splitter #(
    parameter int STAGE_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    issue_pair_splitter_if.slave bus,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing buffered
        FULL  = 2'd1,   // pair buffered, nothing issued yet
        HALF  = 2'd2    // slot0 issued, slot1 still pending
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             vld_q, vld_d;
    logic [1:0]             solo_q, solo_d;
    logic                   dep_q, dep_d;
    logic [STAGE_WIDTH-1:0] b0_q, b0_d;
    logic [STAGE_WIDTH-1:0] b1_q, b1_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic split;
    logic ready;
    logic load;

    // A two-valid pair must serialize when either slot is solo or slot1 reads slot0's result.
    assign split = vld_q[0] & vld_q[1] & ((|solo_q) | dep_q);

    // The buffer frees up in the same cycle it completes an issue, so pairs stream without bubbles.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            EMPTY:   ready = 1'b1;
            FULL:    ready = ~split & ~bus.ex_stall;
            HALF:    ready = ~bus.ex_stall;
            default: ready = 1'b0;
        endcase
        ready = ready & ~bus.flush;
    end

    // A pair with no valid slot is accepted but never stored.
    assign load = bus.in_valid & ready & (|bus.in_slot_vld);

    // Next-state and buffer update; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        solo_d  = solo_q;
        dep_d   = dep_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = EMPTY;
            vld_d   = '0;
            solo_d  = '0;
            dep_d   = 1'b0;
            b0_d    = '0;
            b1_d    = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (load) state_d = FULL;
                end
                FULL: begin
                    if (!bus.ex_stall) begin
                        if (split) begin
                            state_d = HALF;
                            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                        end else begin
                            state_d = load ? FULL : EMPTY;
                        end
                    end
                end
                HALF: begin
                    if (!bus.ex_stall) state_d = load ? FULL : EMPTY;
                end
                default: state_d = EMPTY;
            endcase
            // Buffer contents follow the state: capture on load, clear when draining to EMPTY.
            if (load) begin
                vld_d  = bus.in_slot_vld;
                solo_d = bus.in_solo;
                dep_d  = bus.in_dep;
                b0_d   = bus.in0;
                b1_d   = bus.in1;
            end else if (state_d == EMPTY) begin
                vld_d  = '0;
                solo_d = '0;
                dep_d  = 1'b0;
                b0_d   = '0;
                b1_d   = '0;
            end
        end
    end

    // State, buffer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            vld_q   <= '0;
            solo_q  <= '0;
            dep_q   <= 1'b0;
            b0_q    <= '0;
            b1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            solo_q  <= solo_d;
            dep_q   <= dep_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane drive decoded from state and buffer; an idle lane always carries zeros.
    always_comb begin
        bus.out0         = '0;
        bus.out1         = '0;
        bus.out0_valid   = 1'b0;
        bus.out1_valid   = 1'b0;
        bus.split_active = 1'b0;
        unique case (state_q)
            FULL: begin
                if (split) begin
                    bus.out0_valid   = 1'b1;
                    bus.out0         = b0_q;
                    bus.split_active = 1'b1;
                end else begin
                    bus.out0_valid = vld_q[0];
                    bus.out1_valid = vld_q[1];
                    bus.out0       = vld_q[0] ? b0_q : '0;
                    bus.out1       = vld_q[1] ? b1_q : '0;
                end
            end
            HALF: begin
                bus.out1_valid   = 1'b1;
                bus.out1         = b1_q;
                bus.split_active = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.split_cnt = cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/issue_pair_splitter.md
Name: issue_pair_splitter

Overview:
- Dual-issue dispatch buffer between the decode stage and the two ID/EX pipeline lanes (lane 0, lane 1).
- Accepts one decoded instruction pair per cycle over a valid/ready handshake and holds it in a one-entry pair buffer.
- Issues both slots together when legal. Otherwise it serializes the pair: lane 0 alone in one cycle, then lane 1 alone in the next, with a bubble driven on the idle lane.
- Honours downstream stall and flush, and keeps a saturating count of split pairs.

Parameters:
- STAGE_WIDTH, 32, width of one decoded instruction bundle per lane.
- CNT_WIDTH, 16, width of the split-event performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents a pair
- in_slot_vld  input  2  per-slot valid; bit0 = slot0, bit1 = slot1
- in0  input  STAGE_WIDTH  slot0 bundle
- in1  input  STAGE_WIDTH  slot1 bundle
- in_solo  input  2  per-slot "must issue alone" flag (fence, CSR, multi-cycle op)
- in_dep  input  1  slot1 reads a register written by slot0
- in_ready  output  1  pair accepted this cycle when in_valid & in_ready
- ex_stall  input  1  downstream (ID/EX) cannot take an issue this cycle
- flush  input  1  discard all buffered and pending instructions
- out0  output  STAGE_WIDTH  lane0 bundle; all zeros when out0_valid=0
- out1  output  STAGE_WIDTH  lane1 bundle; all zeros when out1_valid=0
- out0_valid  output  1  lane0 issuing
- out1_valid  output  1  lane1 issuing
- split_active  output  1  pair is being serialized (high in both split cycles)
- split_cnt  output  CNT_WIDTH  saturating count of pairs that were split

Behaviour:
- Reset and clocking: reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: state=EMPTY; buffer and split_cnt cleared; all outputs 0 except in_ready=1 (in_ready is 1 in the cycle following reset).
- States:
  - EMPTY: no pair buffered.
  - FULL: pair buffered, nothing issued yet.
  - HALF: slot0 issued, slot1 pending.
- Outputs are combinational from state and buffer. An accepted pair appears on the outputs in the cycle after acceptance (latency 1).
- Split condition (from buffered flags): split = vld[0] & vld[1] & (solo[0] | solo[1] | dep).
- Output drive by state:
  - FULL, no split: out0_valid=vld[0], out1_valid=vld[1], both lanes driven.
  - FULL, split: out0_valid=1, out1_valid=0, out1=0, split_active=1.
  - HALF: out0_valid=0, out0=0, out1_valid=1, split_active=1.
- Issue completes on a cycle with ex_stall=0. While ex_stall=1, state, buffer and outputs hold unchanged.
- Transitions (ex_stall=0):
  - FULL, no split -> EMPTY, or FULL if a new pair is accepted in the same cycle.
  - FULL, split -> HALF; split_cnt increments here.
  - HALF -> EMPTY, or FULL if a new pair is accepted in the same cycle.
- in_ready = ~flush & (state==EMPTY | (state==FULL & ~split & ~ex_stall) | (state==HALF & ~ex_stall)). No bubble is inserted between back-to-back pairs.
- Slot-valid handling:
  - in_slot_vld=00 with in_valid=1 is accepted and dropped; state stays EMPTY.
  - A single-valid pair never splits; only its valid lane is driven.
- split_cnt saturates at all-ones and does not wrap. It is unaffected by flush and cleared only by rst.
- Flush: highest priority after rst. Next state is EMPTY, the buffer is cleared, and in_ready=0 during the flush cycle (same-cycle input is ignored). Outputs still reflect the current state during the flush cycle, and downstream discards them.
- Simultaneous flush and ex_stall: flush wins.
- Reset mid-split (HALF): return to EMPTY, pending slot1 is lost, split_cnt=0.

Test Plan:
- Reset, then pair {in0=A, in1=B, vld=11, solo=00, dep=0} -> next cycle out0=A, out1=B, both valid, split_active=0; following cycle idle, all outputs 0.
- Pair with dep=1 and ex_stall=0 -> cycle1 out0=A only (out1=0); cycle2 out1=B only (out0=0); split_active high in both cycles; split_cnt=1; in_ready=1 in cycle2 and the next pair issues in cycle3.
- Split pair with ex_stall=1 held 3 cycles in HALF -> out1=B stable for all 4 cycles; B issued exactly once; in_ready=0 while stalled.
- Flush asserted in HALF alongside in_valid=1 -> next cycle EMPTY, all outputs 0, incoming pair not accepted.
- 70000 consecutive solo[0] pairs with CNT_WIDTH=16 -> split_cnt saturates at 65535 (0xFFFF).
- in_slot_vld=10 with solo=11 -> lane1 only in one cycle, no split, split_cnt unchanged.
